// File: rtl/mc_control.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving datapath enables and mux selects,
// with a memory-ready handshake, a sticky illegal-opcode trap and a retired-instruction counter.
module mc_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_SUBI  = 6'b011000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] RTEXE  = 4'd6;
    localparam logic [3:0] RTWB   = 4'd7;
    localparam logic [3:0] ITEXE  = 4'd8;
    localparam logic [3:0] ITWB   = 4'd9;
    localparam logic [3:0] BEQEX  = 4'd10;
    localparam logic [3:0] TRAP   = 4'd11;

    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Next-state, retirement and sticky trap flag.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
                else           state_d = FETCH;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTEXE;
                    OP_SUBI:      state_d = ITEXE;
                    OP_BEQ:       state_d = BEQEX;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      state_d = MEMRD;
                else if (opcode == OP_SW) state_d = MEMWR;
                else                      state_d = TRAP;
            end
            MEMRD: begin
                if (mem_ready) state_d = MEMWB;
                else           state_d = MEMRD;
            end
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = MEMWR;
                end
            end
            MEMWB, RTWB, ITWB, BEQEX: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            RTEXE:   state_d = RTWB;
            ITEXE:   state_d = ITWB;
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase

        illegal_d = illegal_q | (state_d == TRAP);

        if (retire) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else        cnt_d = cnt_q;
    end

    // State, trap flag and retirement counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Moore output decode; rst masks everything so no write can slip out mid-reset.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (rst) begin
            PCWrite = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: ALUSrcB = 2'b11;
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = mem_ready;
                end
                RTEXE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                RTWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                ITEXE: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b01;
                end
                ITWB: RegWrite = 1'b1;
                BEQEX: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                default: PCWrite = 1'b0;
            endcase
        end
    end

    assign illegal     = illegal_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each driven cycle pushes its expected state, controls,
// count and trap flag; a negedge monitor pops and compares against the DUT.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal(illegal), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    logic [15:0] ctl_s;
    assign ctl_s = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    logic exp_ill  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
        case (st)
            4'd0:    return mr ? 16'b1001_0100_0001_0000 : 16'b0001_0000_0001_0000;
            4'd1:    return 16'b0000_0000_0011_0000;
            4'd2:    return 16'b0000_0000_0110_0000;
            4'd3:    return 16'b0011_0000_0000_0000;
            4'd4:    return 16'b0000_0010_1000_0000;
            4'd5:    return mr ? 16'b0010_1000_0000_0000 : 16'b0010_0000_0000_0000;
            4'd6:    return 16'b0000_0000_0100_1000;
            4'd7:    return 16'b0000_0001_1000_0000;
            4'd8:    return 16'b0000_0000_0110_0100;
            4'd9:    return 16'b0000_0000_1000_0000;
            4'd10:   return 16'b0100_0000_0100_0101;
            default: return 16'b0000_0000_0000_0000;
        endcase
    endfunction

    // Monitor: compare each expected cycle half a period after it was driven.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("state", {28'd0, state}, {28'd0, e.st});
            check("ctl", {16'd0, ctl_s}, {16'd0, e.ctl});
            check("instr_count", instr_count, e.cnt);
            check("illegal", {31'd0, illegal}, {31'd0, e.ill});
        end
    end

    // One cycle in state st; opcode/mem_ready are randomised where the FSM must ignore them.
    task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] op);
        if (st == 4'd1 || st == 4'd2) opcode = op;
        else                          opcode = 6'($urandom_range(0, 63));
        if (st == 4'd0 || st == 4'd3 || st == 4'd5) mem_ready = mr;
        else                                        mem_ready = 1'($urandom_range(0, 1));
        if (st == 4'd11) exp_ill = 1'b1;
        q.push_back('{st: st, ctl: exp_ctl(st, mem_ready), cnt: 32'(exp_cnt), ill: exp_ill});
        if (st == 4'd4 || st == 4'd7 || st == 4'd9 || st == 4'd10 || (st == 4'd5 && mem_ready))
            exp_cnt++;
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [5:0] op, input logic [3:0] stall_st, input int stalls);
        logic [3:0] path[$];
        case (op)
            6'b000000: path = '{4'd0, 4'd1, 4'd6, 4'd7};
            6'b011000: path = '{4'd0, 4'd1, 4'd8, 4'd9};
            6'b100011: path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'b101011: path = '{4'd0, 4'd1, 4'd2, 4'd5};
            6'b000100: path = '{4'd0, 4'd1, 4'd10};
            default:   path = '{4'd0, 4'd1};
        endcase
        foreach (path[i]) begin
            if (path[i] == stall_st) repeat (stalls) step(path[i], 1'b0, op);
            step(path[i], 1'b1, op);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {16'd0, ctl_s}, 32'd0);
        check({tag, "_state"}, {28'd0, state}, 32'd0);
        check({tag, "_cnt"}, instr_count, 32'd0);
        check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;

        run(6'b000000, 4'd15, 0);     // R-type: 0,1,6,7
        run(6'b011000, 4'd15, 0);     // SUBI: 0,1,8,9
        run(6'b100011, 4'd3, 2);      // LW with two MEMRD stalls
        run(6'b101011, 4'd5, 1);      // SW with one MEMWR stall
        run(6'b000100, 4'd15, 0);     // BEQ: 0,1,10
        run(6'b000000, 4'd0, 1);      // R-type with a FETCH stall
        step(4'd0, 1'b1, 6'b111111);  // illegal opcode
        step(4'd1, 1'b1, 6'b111111);
        repeat (20) step(4'd11, 1'b1, 6'b000000);

        rst = 1'b1;
        #1;
        check_reset_outputs("trap_clear");
        @(posedge clk);
        #2;
        rst     = 1'b0;
        exp_cnt = 0;
        exp_ill = 1'b0;

        run(6'b000000, 4'd15, 0);
        step(4'd0, 1'b1, 6'b101011);
        step(4'd1, 1'b1, 6'b101011);
        step(4'd2, 1'b1, 6'b101011);
        mem_ready = 1'b1;             // now in MEMWR with memory ready
        #1;
        check("sw_memwrite_on", {31'd0, MemWrite}, 32'd1);
        check("sw_state", {28'd0, state}, 32'd5);
        rst = 1'b1;
        #1;
        check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        check_reset_outputs("abort");
        @(posedge clk);
        #2;
        rst     = 1'b0;
        exp_cnt = 0;
        exp_ill = 1'b0;

        run(6'b011000, 4'd15, 0);
        #10;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle sequencer for the MIPS datapath (OR, SUBI, SW, BEQ, plus LW).
- Replaces the single-cycle combinational control unit when the datapath shares one memory for instructions and data and holds intermediate values in IR/A/B/ALUOut registers.
- A Moore FSM drives all datapath enables and mux selects, waits on a memory-ready handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode; OR is selected by funct in the ALU control unit, not here.
- OP_SUBI, 6'b011000, SUBI opcode.
- OP_LW, 6'b100011, load word opcode.
- OP_SW, 6'b101011, store word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the IR.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero (BEQ).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemToReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct.
- PCSource  out  2  00 = ALU result, 01 = ALUOut (branch target).
- illegal  out  1  sticky flag: unknown opcode was trapped.
- state  out  4  current FSM state, for debug.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (asynchronous):
  - state = FETCH (0), instr_count = 0, illegal = 0.
  - While rst is high, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0.
  - All other outputs are 0 during reset.
  - Reset asserted mid-instruction aborts it; no partial write completes after rst rises.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, RTWB 7, ITEXE 8, ITWB 9, BEQEX 10, TRAP 11. Codes 12–15 go to TRAP.
- Outputs are Moore (decoded from state), except that memory-completion enables are ANDed with mem_ready. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
  - Transition: to DECODE when mem_ready, otherwise stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target).
  - Transitions: LW/SW → MEMADR; R-type → RTEXE; SUBI → ITEXE; BEQ → BEQEX; any other opcode → TRAP.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Transitions: LW → MEMRD, SW → MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Transition: to MEMWB when mem_ready, otherwise stay.
- MEMWB:
  - Outputs: RegWrite=1, RegDst=0, MemToReg=1.
  - Transition: FETCH; retires the instruction.
- MEMWR:
  - Outputs: IorD=1, MemWrite=mem_ready.
  - Transition: when mem_ready → FETCH and retire; otherwise stay, with MemWrite held low.
- RTEXE:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Transition: RTWB.
- RTWB:
  - Outputs: RegWrite=1, RegDst=1, MemToReg=0.
  - Transition: FETCH; retires.
- ITEXE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=01 (SUBI is rs − imm).
  - Transition: ITWB.
- ITWB:
  - Outputs: RegWrite=1, RegDst=0, MemToReg=0.
  - Transition: FETCH; retires.
- BEQEX:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Transition: FETCH; retires whether or not the branch is taken.
- TRAP:
  - illegal is set to 1 on entry; the FSM stays in TRAP until reset.
  - All enables are 0; instr_count is frozen.
- instr_count:
  - Increments by 1 on the edge that leaves MEMWB, RTWB, ITWB or BEQEX, or leaves MEMWR with mem_ready=1.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
- Cycle counts with mem_ready held at 1: R-type 4, SUBI 4, BEQ 3, SW 4, LW 5.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- The opcode input is sampled only in DECODE and MEMADR. The IR is stable after FETCH, so opcode changes in other states have no effect.

Test Plan:
- Reset release with mem_ready=1 and opcode=000000 → states 0,1,6,7,0; RegWrite=1 only in state 7 with RegDst=1; instr_count=1 after 4 cycles.
- SUBI (011000) with mem_ready=1 → states 0,1,8,9; ALUOp=01 and ALUSrcB=10 in state 8; RegDst=0 in state 9; instr_count=1.
- LW (100011) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4; MemToReg=1 in state 4; total 7 cycles; instr_count=1.
- SW (101011) with mem_ready=0 for 1 cycle in MEMWR → MemWrite=0 on the first MEMWR cycle and 1 on the second; RegWrite never asserted; return to FETCH.
- BEQ (000100) → states 0,1,10; PCWriteCond=1, PCSource=01, ALUOp=01 in state 10; 3 cycles; PCWrite=0 in state 10.
- Opcode 111111 in DECODE → TRAP (11); illegal=1 and all enables 0 for 20 cycles; instr_count unchanged. Assert rst mid-SW in MEMWR → MemWrite drops immediately, state=0, illegal=0.
